crc_lut_seq: RTL

//  - Byte-serial sequencer for one external 256x32 CRC lookup table (combinational read).
//  - Accepts 32-bit words on a valid/ready stream and issues one table lookup per byte.
//  - Holds the running CRC and returns the final CRC with a valid/ready handshake.
//  - Sits between a packet source and a crctab_* instance; one sequencer per table.

---
 rtl/crc_lut_pkg.sv | 16 +
 rtl/crc_lut_seq_if.sv | 24 ++
 rtl/crc_lut_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/crc_lut_pkg.sv
// Shared types and constants for the byte-serial CRC table sequencer.
package crc_lut_pkg;

  localparam int CRC_W     = 32;
  localparam int TAB_IDX_W = 8;

  localparam logic [CRC_W-1:0] DEF_INIT   = 32'hFFFF_FFFF;
  localparam logic [CRC_W-1:0] DEF_XOROUT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/crc_lut_seq_if.sv
// Word input stream and CRC result stream of the sequencer, bundled as one interface.
interface crc_lut_seq_if;
  import crc_lut_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [CRC_W-1:0] in_data;
  logic             in_last;
  logic [2:0]       in_nbytes;
  logic             crc_valid;
  logic             crc_ready;
  logic [CRC_W-1:0] crc_out;

  modport master (
    output in_valid, in_data, in_last, in_nbytes, crc_ready,
    input  in_ready, crc_valid, crc_out
  );

  modport slave (
    input  in_valid, in_data, in_last, in_nbytes, crc_ready,
    output in_ready, crc_valid, crc_out
  );

endinterface

// File: rtl/crc_lut_seq.sv
// Byte-serial CRC sequencer: one lookup per byte into an external 256x32 table.
// Build option: define CRC_XOROUT_EN to XOR XOROUT into the final CRC.
module crc_lut_seq
  import crc_lut_pkg::*;
#(
  parameter logic [CRC_W-1:0] INIT   = DEF_INIT,
  parameter logic [CRC_W-1:0] XOROUT = DEF_XOROUT
) (
  input  logic             clk,
  input  logic             rst,
  crc_lut_seq_if.slave     bus,
  output logic [CRC_W-1:0] tab_addr,
  input  logic [CRC_W-1:0] tab_rdata,
  output logic             busy
);

`ifdef CRC_XOROUT_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif
  localparam logic [CRC_W-1:0] XOR_MASK = XOR_EN ? XOROUT : '0;

  state_t                 state, state_nx;
  logic [CRC_W-1:0]       crc_q, crc_nx, crc_out_q, word_q;
  logic                   last_q;
  logic [2:0]             nb_q;
  logic [1:0]             byte_idx;
  logic [TAB_IDX_W-1:0]   byte_sel, tab_idx;
  logic                   last_byte, accept, finish;

  function automatic logic [CRC_W-1:0] finalize(input logic [CRC_W-1:0] c);
    return c ^ XOR_MASK;
  endfunction

  // Non-last words always carry four bytes; out-of-range counts fall back to four.
  function automatic logic [2:0] norm_nbytes(input logic last, input logic [2:0] nb);
    if (!last || nb == 3'd0 || nb > 3'd4) return 3'd4;
    return nb;
  endfunction

  always_comb begin
    case (byte_idx)
      2'd0:    byte_sel = word_q[31:24];
      2'd1:    byte_sel = word_q[23:16];
      2'd2:    byte_sel = word_q[15:8];
      default: byte_sel = word_q[7:0];
    endcase
  end

  assign tab_idx   = crc_q[CRC_W-1 -: TAB_IDX_W] ^ byte_sel;
  assign crc_nx    = {crc_q[CRC_W-TAB_IDX_W-1:0], {TAB_IDX_W{1'b0}}} ^ tab_rdata;
  assign last_byte = ({1'b0, byte_idx} == nb_q - 3'd1);
  assign accept    = (state == IDLE) && bus.in_valid;
  assign finish    = (state == RUN) && last_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = RUN;
      RUN:     if (last_byte)    state_nx = last_q ? DONE : IDLE;
      DONE:    if (bus.crc_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.crc_valid = (state == DONE);
    busy          = (state != IDLE);
    tab_addr      = '0;
    if (state == RUN) tab_addr = {{(CRC_W-TAB_IDX_W){1'b0}}, tab_idx};
  end

  assign bus.crc_out = crc_out_q;

  // crc_q carries across words of a frame and reloads INIT once the result is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q     <= INIT;
      crc_out_q <= '0;
      byte_idx  <= 2'd0;
      last_q    <= 1'b0;
      nb_q      <= 3'd4;
    end else begin
      if (accept) begin
        byte_idx <= 2'd0;
        last_q   <= bus.in_last;
        nb_q     <= norm_nbytes(bus.in_last, bus.in_nbytes);
      end else if (state == RUN) begin
        if (finish && last_q) begin
          crc_q     <= INIT;
          crc_out_q <= finalize(crc_nx);
        end else begin
          crc_q <= crc_nx;
        end
        if (!last_byte) byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) word_q <= bus.in_data;
  end

endmodule
